sdram_arbmod: RTL and testbench
===============================

SDRAM_ARBMOD -- requirements
Module: sdram_arbmod

Interface
REQ-001 SHALL have parameter AW, default 22, meaning SDRAM address width {bank,row,column}.
REQ-002 SHALL have parameter DW, default 16, meaning SDRAM data width.
REQ-003 SHALL have parameter TMAX, default 16'd4095, meaning downstream watchdog limit in clocks.
REQ-004 SHALL have port CLOCK  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports iCallA/iCallB  input  2 each  client request, [1]Write [0]Read, held high until done.
REQ-007 SHALL have ports oDoneA/oDoneB  output  2 each  one-cycle completion pulse, [1]Write [0]Read.
REQ-008 SHALL have ports iAddrA/iAddrB  input  AW each  client address.
REQ-009 SHALL have ports iDataA/iDataB  input  DW each  client write data.
REQ-010 SHALL have ports oDataA/oDataB  output  DW each  registered read data per client.
REQ-011 SHALL have ports oCall output 2, iDone input 2, oAddr output AW, oData output DW, iData input DW: downstream SDRAM controller port, same [1]Write [0]Read encoding.
REQ-012 SHALL have port oErr  output  1  sticky watchdog-timeout flag.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE, GAP.
REQ-014 IDLE: if any client call bit set, select winner, register its address, write data and op, enter BUSY next cycle; else stay.
REQ-015 Within one client, Write SHALL win over Read when both bits set.
REQ-016 Winner between clients SHALL follow REQ-033/REQ-034.
REQ-017 BUSY: oCall SHALL carry exactly one bit (granted op) and hold oAddr/oData stable until iDone matching bit seen.
REQ-018 On iDone[0] in BUSY: latch iData into granted client's oData register same edge; other client's oData unchanged.
REQ-019 On matching iDone bit: drop oCall same edge, enter DONE.
REQ-020 DONE: assert granted client's oDone bit for exactly one cycle, enter GAP.
REQ-021 GAP: one idle cycle (client drops call), then IDLE; a call still present in IDLE after GAP SHALL be treated as new request.
REQ-022 Grant-to-oCall latency SHALL be 1 clock from IDLE; done-to-client oDone latency 1 clock after iDone.
REQ-023 iDone bit not matching granted op, or iDone in IDLE/DONE/GAP, SHALL be ignored.
REQ-024 Client call changes during BUSY SHALL not affect registered address, data or op.
REQ-025 Watchdog: 16-bit counter clears on BUSY entry, increments each BUSY cycle; at TMAX SHALL set oErr, drop oCall, enter IDLE without client oDone.
REQ-026 oErr SHALL clear only on reset.
REQ-027 Only one client SHALL hold grant at any time; never both oDone vectors nonzero.

Reset
REQ-028 RESET low SHALL asynchronously force state IDLE, oCall=0, oDoneA=oDoneB=0, oErr=0.
REQ-029 RESET low SHALL force oAddr=0, oData=0, oDataA=oDataB=0, watchdog=0, last-grant pointer=B (so A wins first tie).
REQ-030 Reset mid-BUSY SHALL abandon transaction; no oDone pulse after release.
REQ-031 First grant SHALL be possible on second rising edge after RESET deasserts.
REQ-032 Downstream controller's own init/refresh latency SHALL appear only as longer BUSY time, no special handling.

Configuration
REQ-033 With SDRAM_ARB_RR_EN defined: round-robin; on tie, client not granted last wins; pointer updates on each DONE.
REQ-034 Without SDRAM_ARB_RR_EN: fixed priority, client A always wins ties; no pointer register.

Verification
REQ-035 A write only: iCallA=2'b10, iAddrA=22'h000100, iDataA=16'hA5A5, iDone[1] after 10 clocks -> oCall=2'b10, oAddr=22'h000100, oData=16'hA5A5, one oDoneA[1] pulse.
REQ-036 B read: iCallB=2'b01, iData=16'h1234 with iDone[0] -> oDataB=16'h1234, oDoneB[0] pulse, oDataA unchanged.
REQ-037 Simultaneous A/B writes held continuously: with RR_EN grants A,B,A,B; without RR_EN grants A,A,A; B starved.
REQ-038 iCallA=2'b11 -> write served first, read served on next grant.
REQ-039 iDone never returned, TMAX=16'd20 -> oCall drops after 20 BUSY cycles, oErr=1, no oDoneA.
REQ-040 RESET pulsed low mid-BUSY -> all outputs 0 immediately, no oDone after release, next request served normally.

Source files
------------

// File: rtl/sdram_arbmod.sv
// Two-client SDRAM arbiter: grants one client at a time onto a single downstream controller port.
// Latency: oCall rises 1 clock after a call is seen in IDLE; client oDone pulses 1 clock after iDone.
// Backpressure: clients hold iCall until their oDone; the downstream port holds oCall until iDone or watchdog.
// Ports: CLOCK/RESET (async active-low); iCallA/B, iAddrA/B, iDataA/B in, oDoneA/B, oDataA/B out per client;
//        oCall/oAddr/oData out, iDone/iData in towards the SDRAM controller; oErr sticky watchdog flag.
// Build option: define SDRAM_ARB_RR_EN for round-robin between clients, otherwise client A has fixed priority.
module sdram_arbmod #(
    parameter int          AW   = 22,
    parameter int          DW   = 16,
    parameter logic [15:0] TMAX = 16'd4095
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic [1:0]    iCallA,
    input  logic [1:0]    iCallB,
    output logic [1:0]    oDoneA,
    output logic [1:0]    oDoneB,
    input  logic [AW-1:0] iAddrA,
    input  logic [AW-1:0] iAddrB,
    input  logic [DW-1:0] iDataA,
    input  logic [DW-1:0] iDataB,
    output logic [DW-1:0] oDataA,
    output logic [DW-1:0] oDataB,
    output logic [1:0]    oCall,
    input  logic [1:0]    iDone,
    output logic [AW-1:0] oAddr,
    output logic [DW-1:0] oData,
    input  logic [DW-1:0] iData,
    output logic          oErr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

    state_t      state;
    logic        gnt_b;   // 1 when client B owns the current transaction
    logic [1:0]  op;      // granted operation, one-hot [1]Write [0]Read
    logic        armed;   // delays the first grant to the second edge after reset release
    logic [15:0] wdog;

    logic       req_a;
    logic       req_b;
    logic       pick_b;
    logic [1:0] win_call;
    logic [1:0] win_op;

    assign req_a = |iCallA;
    assign req_b = |iCallB;

`ifdef SDRAM_ARB_RR_EN
    logic last_b;   // client granted by the most recent completed transaction
    // On a tie the client that was not served last wins.
    assign pick_b = req_b & (~req_a | ~last_b);
`else
    assign pick_b = req_b & ~req_a;
`endif

    assign win_call = pick_b ? iCallB : iCallA;
    // Write beats read inside one client.
    assign win_op   = win_call[1] ? 2'b10 : 2'b01;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            gnt_b  <= 1'b0;
            op     <= 2'b00;
            armed  <= 1'b0;
            wdog   <= 16'd0;
            oCall  <= 2'b00;
            oAddr  <= '0;
            oData  <= '0;
            oDataA <= '0;
            oDataB <= '0;
            oDoneA <= 2'b00;
            oDoneB <= 2'b00;
            oErr   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_b <= 1'b1;
`endif
        end else begin
            // Done strobes are single-cycle: cleared unless set below.
            oDoneA <= 2'b00;
            oDoneB <= 2'b00;
            armed  <= 1'b1;
            case (state)
                IDLE: begin
                    if (armed && (req_a || req_b)) begin
                        gnt_b <= pick_b;
                        op    <= win_op;
                        oCall <= win_op;
                        oAddr <= pick_b ? iAddrB : iAddrA;
                        oData <= pick_b ? iDataB : iDataA;
                        wdog  <= 16'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if ((iDone & op) != 2'b00) begin
                        oCall <= 2'b00;
                        if (op[0]) begin
                            if (gnt_b) oDataB <= iData;
                            else       oDataA <= iData;
                        end
                        if (gnt_b) oDoneB <= op;
                        else       oDoneA <= op;
                        state <= DONE;
                    end else if (wdog == TMAX - 16'd1) begin
                        // TMAX busy cycles elapsed without completion: abandon silently.
                        oErr  <= 1'b1;
                        oCall <= 2'b00;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                DONE: begin
`ifdef SDRAM_ARB_RR_EN
                    last_b <= gnt_b;
`endif
                    state <= GAP;
                end
                default: begin
                    // GAP: lets the client withdraw its call before IDLE samples again.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbmod.sv
// Self-checking bench for sdram_arbmod: directed scenarios plus randomized rounds against a transaction model.
// The model predicts the winner, op, addresses, data and read-back registers per transaction.
// Downstream responses use random latency and occasional non-matching iDone pulses.
module tb_sdram_arbmod;
    localparam int AW = 22;
    localparam int DW = 16;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    call_a = 2'b00, call_b = 2'b00;
    logic [1:0]    done_a, done_b;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdat_a = '0, wdat_b = '0;
    logic [DW-1:0] rdat_a, rdat_b;
    logic [1:0]    dn_call;
    logic [1:0]    dn_done = 2'b00;
    logic [AW-1:0] dn_addr;
    logic [DW-1:0] dn_wdat;
    logic [DW-1:0] dn_rdat = '0;
    logic          err;

    always #5 clk = ~clk;

    sdram_arbmod #(.AW(AW), .DW(DW), .TMAX(16'd20)) dut (
        .CLOCK(clk), .RESET(rst_n),
        .iCallA(call_a), .iCallB(call_b),
        .oDoneA(done_a), .oDoneB(done_b),
        .iAddrA(addr_a), .iAddrB(addr_b),
        .iDataA(wdat_a), .iDataB(wdat_b),
        .oDataA(rdat_a), .oDataB(rdat_b),
        .oCall(dn_call), .iDone(dn_done),
        .oAddr(dn_addr), .oData(dn_wdat), .iData(dn_rdat),
        .oErr(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state
    logic [1:0]    pend_a = 2'b00, pend_b = 2'b00;
    logic [DW-1:0] exp_ra = '0, exp_rb = '0;
    bit            last_b_m = 1'b1;
    int            done_a_cnt = 0, done_b_cnt = 0;

    always @(negedge clk) begin
        if (|done_a) done_a_cnt++;
        if (|done_b) done_b_cnt++;
        if (rst_n) chk("done_exclusive", 32'((|done_a) && (|done_b)), 32'd0);
    end

    // One granted transaction: predict winner, check grant, respond, check completion.
    task automatic serve(input int lat, input bit hold, input bit spur);
        bit         wb;
        logic [1:0] op;
        logic [1:0] wcall;
        logic [DW-1:0] rd;
        int n;
        if ((|pend_a) && (|pend_b)) wb = RR ? !last_b_m : 1'b0;
        else                        wb = |pend_b;
        wcall = wb ? pend_b : pend_a;
        op = wcall[1] ? 2'b10 : 2'b01;
        n = 0;
        while (dn_call == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 32'(n < 30), 32'd1);
        chk("ocall", 32'(dn_call), 32'(op));
        chk("oaddr", 32'(dn_addr), 32'(wb ? addr_b : addr_a));
        chk("odata_dn", 32'(dn_wdat), 32'(wb ? wdat_b : wdat_a));
        chk("err_clear", 32'(err), 32'd0);
        for (int i = 0; i < lat; i++) begin
            if (spur && i == 0) begin
                dn_done = ~op;
                dn_rdat = DW'($urandom);
            end
            @(negedge clk);
            dn_done = 2'b00;
            chk("hold_call", 32'(dn_call), 32'(op));
            chk("hold_addr", 32'(dn_addr), 32'(wb ? addr_b : addr_a));
        end
        rd = DW'($urandom);
        dn_rdat = rd;
        dn_done = op;
        @(negedge clk);
        dn_done = 2'b00;
        chk("done_win", 32'(wb ? done_b : done_a), 32'(op));
        chk("done_lose", 32'(wb ? done_a : done_b), 32'd0);
        chk("ocall_drop", 32'(dn_call), 32'd0);
        if (op[0]) begin
            if (wb) exp_rb = rd;
            else    exp_ra = rd;
        end
        chk("rdata_a", 32'(rdat_a), 32'(exp_ra));
        chk("rdata_b", 32'(rdat_b), 32'(exp_rb));
        last_b_m = wb;
        if (!hold) begin
            if (wb) pend_b = pend_b & ~op;
            else    pend_a = pend_a & ~op;
            call_a = pend_a;
            call_b = pend_b;
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a | done_b), 32'd0);
    endtask

    task automatic round(input logic [1:0] ca, input logic [1:0] cb, input bit hold,
                         input int ngr, input int lat);
        int k;
        pend_a = ca;
        pend_b = cb;
        call_a = ca;
        call_b = cb;
        k = 0;
        while (k < ngr && (pend_a != 2'b00 || pend_b != 2'b00)) begin
            serve(lat < 0 ? $urandom_range(0, 6) : lat, hold, $urandom_range(0, 3) == 0);
            k++;
        end
        pend_a = 2'b00;
        pend_b = 2'b00;
        call_a = 2'b00;
        call_b = 2'b00;
        repeat (3) @(negedge clk);
        chk("idle_after_round", 32'(dn_call), 32'd0);
    endtask

    task automatic do_reset_model();
        exp_ra = '0;
        exp_rb = '0;
        last_b_m = 1'b1;
    endtask

    initial begin
        int n;
        int da0;
        int db0;
        // Reset values and first-grant timing
        call_a = 2'b01;
        addr_a = 22'h0ABCDE;
        wdat_a = 16'h5555;
        repeat (3) @(negedge clk);
        chk("rst_ocall", 32'(dn_call), 32'd0);
        chk("rst_oaddr", 32'(dn_addr), 32'd0);
        chk("rst_odata", 32'(dn_wdat), 32'd0);
        chk("rst_rdata", 32'({rdat_a, rdat_b}), 32'd0);
        chk("rst_done", 32'({done_a, done_b}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_grant_edge1", 32'(dn_call), 32'd0);
        @(negedge clk);
        chk("grant_edge2", 32'(dn_call), 32'd1);
        round(2'b01, 2'b00, 1'b0, 4, 2);

        // A write only, 10-clock downstream latency
        addr_a = 22'h000100;
        wdat_a = 16'hA5A5;
        round(2'b10, 2'b00, 1'b0, 4, 10);

        // B read
        addr_b = 22'h012345;
        round(2'b00, 2'b01, 1'b0, 4, 3);

        // Both clients writing continuously
        round(2'b10, 2'b10, 1'b1, 4, 1);

        // Write and read together in one client
        round(2'b11, 2'b00, 1'b0, 4, 2);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            logic [1:0] ca;
            logic [1:0] cb;
            ca = 2'($urandom_range(0, 3));
            cb = 2'($urandom_range(0, 3));
            addr_a = AW'($urandom);
            addr_b = AW'($urandom);
            wdat_a = DW'($urandom);
            wdat_b = DW'($urandom);
            round(ca, cb, $urandom_range(0, 4) == 0, 4, -1);
        end

        // Watchdog: never answer
        da0 = done_a_cnt;
        pend_a = 2'b10;
        call_a = 2'b10;
        n = 0;
        while (dn_call == 2'b00 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wd_grant", 32'(dn_call), 32'd2);
        n = 0;
        while (dn_call != 2'b00 && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("wd_busy_cycles", 32'(n), 32'd20);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_no_done", 32'(done_a_cnt - da0), 32'd0);
        // Held call is re-granted; error flag stays set
        repeat (3) @(negedge clk);
        chk("wd_regrant", 32'(dn_call), 32'd2);
        chk("wd_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of BUSY
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ocall", 32'(dn_call), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_addr", 32'(dn_addr), 32'd0);
        chk("mid_rst_rdata", 32'({rdat_a, rdat_b}), 32'd0);
        do_reset_model();
        call_a = 2'b00;
        pend_a = 2'b00;
        da0 = done_a_cnt;
        db0 = done_b_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_done", 32'((done_a_cnt - da0) + (done_b_cnt - db0)), 32'd0);
        chk("mid_rst_idle", 32'(dn_call), 32'd0);
        addr_b = 22'h3FFFFF;
        wdat_b = 16'hBEEF;
        round(2'b11, 2'b01, 1'b0, 6, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
